// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch shared types: exception causes, opcodes, FSM states,
// fetch->decode bundle and J/B immediate extractors.
package rv32_fetch_pkg;

  localparam logic [3:0] RV32_MCAUSE_INSTR_MISALIGNED_EXCEPTION = 4'd0;
  localparam logic [3:0] RV32_MCAUSE_INSTR_FAULT_EXCEPTION      = 4'd1;

  localparam logic [6:0] RV32_OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] RV32_OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_SKID,
    FETCH_HALT
  } fetch_state_t;

  typedef struct packed {
    logic        exc;
    logic [3:0]  cause;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/rv32_fetch_if.sv
// Instruction bus between fetch (master) and memory (slave):
// address/read request out, ready/data/fault back.
interface rv32_fetch_if;
  import rv32_fetch_pkg::*;

  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic        instr_ready_in;
  logic [31:0] instr_read_value_in;
  logic        instr_fault_in;

  modport master (
    output instr_address_out,
    output instr_read_out,
    input  instr_ready_in,
    input  instr_read_value_in,
    input  instr_fault_in
  );

  modport slave (
    input  instr_address_out,
    input  instr_read_out,
    output instr_ready_in,
    output instr_read_value_in,
    output instr_fault_in
  );
endinterface

// File: rtl/rv32_branch_predictor.sv
// Static predictor: pc_in/instr_in -> taken_out/target_out.
// target_out is the next fetch PC (pc+4 when not taken).
module rv32_branch_predictor
  import rv32_fetch_pkg::*;
(
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        taken_out,
  output logic [31:0] target_out
);

  logic w_jal;
  logic w_br;

  assign w_jal = instr_in[6:0] == RV32_OPCODE_JAL;
  assign w_br  = instr_in[6:0] == RV32_OPCODE_BRANCH;

  always_comb begin
    taken_out  = 1'b0;
    target_out = pc_in + 32'd4;
    unique case (1'b1)
      w_jal: begin
        taken_out  = 1'b1;
        target_out = pc_in + imm_j(instr_in);
      end
      w_br: begin
        // backward branches (negative offset) predicted taken
        taken_out = instr_in[31];
        if (instr_in[31])
          target_out = pc_in + imm_b(instr_in);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_fetch.sv
// RV32 fetch stage: PC, bus read handshake (bus), static prediction,
// registered valid/exception/cause/pred/pc/instr toward decode.
module rv32_fetch
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_in,
  input  logic         flush_in,
  input  logic         branch_mispredicted_in,
  input  logic [31:0]  branch_pc_in,
  input  logic         trap_in,
  input  logic [31:0]  trap_pc_in,
  rv32_fetch_if.master bus,
  output logic         valid_out,
  output logic         exception_out,
  output logic [3:0]   exception_cause_out,
  output logic         branch_predicted_taken_out,
  output logic [31:0]  pc_out,
  output logic [31:0]  instr_out
);

  fetch_state_t r_state;
  fetch_state_t w_next;
  logic [31:0]  r_pc;
  logic         r_pend_vld;
  logic [31:0]  r_pend_pc;
  if_id_t       r_skid;
  if_id_t       r_out;
  logic         r_valid;

  logic         w_redir;
  logic [31:0]  w_redir_pc;
  logic         w_fire;
  logic         w_hold;
  logic         w_jump;
  logic [31:0]  w_tgt;
  logic         w_mis;
  logic         w_word;
  logic         w_rel;
  logic         w_taken;
  logic [31:0]  w_target;
  logic         w_ev_vld;
  if_id_t       w_ev;
  logic [31:0]  w_pc_nxt;

  rv32_branch_predictor u_bp (
    .pc_in      (r_pc),
    .instr_in   (bus.instr_read_value_in),
    .taken_out  (w_taken),
    .target_out (w_target)
  );

  // trap wins over mispredict
  assign w_redir    = trap_in | branch_mispredicted_in;
  assign w_redir_pc = trap_in ? trap_pc_in : branch_pc_in;
  assign w_fire     = (r_state == FETCH_REQ) & bus.instr_ready_in;
  // redirect while a request is outstanding: park it
  assign w_hold     = (r_state == FETCH_REQ)
                    & ~bus.instr_ready_in & w_redir;

  always_comb begin
    w_jump = 1'b0;
    w_tgt  = w_redir_pc;
    if (w_redir && (r_state != FETCH_REQ
                    || bus.instr_ready_in)) begin
      w_jump = 1'b1;
    end else if (w_fire && r_pend_vld) begin
      w_jump = 1'b1;
      w_tgt  = r_pend_pc;
    end
  end

  assign w_mis  = w_jump & (w_tgt[1:0] != 2'b00);
  assign w_word = w_fire & ~w_jump;
  assign w_rel  = (r_state == FETCH_SKID)
                & ~stall_in & ~w_redir;

  always_comb begin
    w_ev_vld = 1'b0;
    w_ev     = '0;
    if (w_mis) begin
      w_ev_vld = 1'b1;
      w_ev.exc = 1'b1;
      w_ev.cause = RV32_MCAUSE_INSTR_MISALIGNED_EXCEPTION;
      w_ev.pc  = w_tgt;
    end else if (w_word) begin
      w_ev_vld = 1'b1;
      w_ev.pc  = r_pc;
      if (bus.instr_fault_in) begin
        w_ev.exc   = 1'b1;
        w_ev.cause = RV32_MCAUSE_INSTR_FAULT_EXCEPTION;
      end else begin
        w_ev.pred  = w_taken;
        w_ev.instr = bus.instr_read_value_in;
      end
    end
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_jump)
      w_pc_nxt = w_tgt;
    else if (w_word && !bus.instr_fault_in)
      w_pc_nxt = w_target;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_ev_vld) begin
      if (stall_in)      w_next = FETCH_SKID;
      else if (w_ev.exc) w_next = FETCH_HALT;
      else               w_next = FETCH_REQ;
    end else if (w_jump) begin
      w_next = FETCH_REQ;
    end else begin
      unique case (r_state)
        FETCH_IDLE: w_next = FETCH_REQ;
        FETCH_SKID:
          if (!stall_in)
            w_next = r_skid.exc ? FETCH_HALT : FETCH_REQ;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.instr_read_out    = r_state == FETCH_REQ;
    bus.instr_address_out = r_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
      r_skid     <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_hold) begin
        r_pend_vld <= 1'b1;
        r_pend_pc  <= w_redir_pc;
      end else if (w_jump || w_fire) begin
        r_pend_vld <= 1'b0;
      end
      if (w_ev_vld && stall_in)
        r_skid <= w_ev;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (!stall_in) begin
      if (w_rel) begin
        r_valid <= 1'b1;
        r_out   <= r_skid;
      end else if (w_ev_vld) begin
        r_valid <= 1'b1;
        r_out   <= w_ev;
      end else begin
        r_valid   <= 1'b0;
        r_out.exc  <= 1'b0;
        r_out.pred <= 1'b0;
      end
      if (flush_in) begin
        r_valid    <= 1'b0;
        r_out.exc  <= 1'b0;
        r_out.pred <= 1'b0;
      end
    end
  end

  assign valid_out                  = r_valid;
  assign exception_out              = r_out.exc;
  assign exception_cause_out        = r_out.cause;
  assign branch_predicted_taken_out = r_out.pred;
  assign pc_out                     = r_out.pc;
  assign instr_out                  = r_out.instr;

endmodule

// File: tb/tb_rv32_fetch.sv
// Directed bench for rv32_fetch with a combinational memory:
// NOP everywhere, backward beq at 0x100, access fault at 0x40.
module tb_rv32_fetch;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        flush_in;
  logic        branch_mispredicted_in;
  logic [31:0] branch_pc_in;
  logic        trap_in;
  logic [31:0] trap_pc_in;
  logic        valid_out;
  logic        exception_out;
  logic [3:0]  exception_cause_out;
  logic        branch_predicted_taken_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        mem_en;

  int n_cmp;
  int n_err;

  rv32_fetch_if bus();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hFE000EE3 : 32'h0000_0013;
  endfunction

  assign bus.instr_ready_in      = bus.instr_read_out & mem_en;
  assign bus.instr_read_value_in = mem_word(bus.instr_address_out);
  assign bus.instr_fault_in      = bus.instr_address_out == 32'h40;

  rv32_fetch #(.RESET_PC(32'h0)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .stall_in                   (stall_in),
    .flush_in                   (flush_in),
    .branch_mispredicted_in     (branch_mispredicted_in),
    .branch_pc_in               (branch_pc_in),
    .trap_in                    (trap_in),
    .trap_pc_in                 (trap_pc_in),
    .bus                        (bus),
    .valid_out                  (valid_out),
    .exception_out              (exception_out),
    .exception_cause_out        (exception_cause_out),
    .branch_predicted_taken_out (branch_predicted_taken_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    stall_in = 1'b0;
    flush_in = 1'b0;
    branch_mispredicted_in = 1'b0;
    branch_pc_in = '0;
    trap_in = 1'b0;
    trap_pc_in = '0;
    mem_en = 1'b0;
    tick();
    tick();
    chk("rst_valid", valid_out, 0);
    chk("rst_exc", exception_out, 0);
    chk("rst_cause", exception_cause_out, 0);
    chk("rst_pred", branch_predicted_taken_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_read", bus.instr_read_out, 0);
    chk("rst_addr", bus.instr_address_out, 32'h0);

    // zero-wait NOP stream
    reset = 1'b0;
    mem_en = 1'b1;
    tick();
    chk("first_read", bus.instr_read_out, 1);
    chk("first_addr", bus.instr_address_out, 32'h0);
    tick();
    chk("seq0_valid", valid_out, 1);
    chk("seq0_pc", pc_out, 32'h0);
    chk("seq0_instr", instr_out, 32'h13);
    chk("seq0_addr", bus.instr_address_out, 32'h4);
    tick();
    chk("seq1_pc", pc_out, 32'h4);
    chk("seq1_valid", valid_out, 1);
    tick();
    chk("seq2_pc", pc_out, 32'h8);

    // redirect with ready, then backward beq at 0x100
    branch_mispredicted_in = 1'b1;
    branch_pc_in = 32'h100;
    tick();
    branch_mispredicted_in = 1'b0;
    chk("redir_drop_valid", valid_out, 0);
    chk("redir_addr", bus.instr_address_out, 32'h100);
    tick();
    chk("beq_pred", branch_predicted_taken_out, 1);
    chk("beq_pc", pc_out, 32'h100);
    chk("beq_instr", instr_out, 32'hFE000EE3);
    chk("beq_next_addr", bus.instr_address_out, 32'hFC);

    // 3-cycle stall, response arrives during stall
    mem_en = 1'b0;
    stall_in = 1'b1;
    tick();
    chk("stall1_pc", pc_out, 32'h100);
    chk("stall1_valid", valid_out, 1);
    mem_en = 1'b1;
    tick();
    chk("stall2_read", bus.instr_read_out, 0);
    chk("stall2_pc", pc_out, 32'h100);
    tick();
    chk("stall3_read", bus.instr_read_out, 0);
    chk("stall3_pred", branch_predicted_taken_out, 1);
    stall_in = 1'b0;
    tick();
    chk("skid_pc", pc_out, 32'hFC);
    chk("skid_valid", valid_out, 1);
    chk("skid_pred", branch_predicted_taken_out, 0);
    chk("skid_read", bus.instr_read_out, 1);
    chk("skid_addr", bus.instr_address_out, 32'h100);
    tick();
    chk("post_skid_pc", pc_out, 32'h100);

    // mispredict while the request waits 2 cycles
    mem_en = 1'b0;
    tick();
    chk("wait_bubble", valid_out, 0);
    branch_mispredicted_in = 1'b1;
    branch_pc_in = 32'h200;
    tick();
    branch_mispredicted_in = 1'b0;
    chk("pend_addr_hold", bus.instr_address_out, 32'hFC);
    chk("pend_read", bus.instr_read_out, 1);
    tick();
    chk("pend_valid", valid_out, 0);
    mem_en = 1'b1;
    tick();
    chk("stale_drop", valid_out, 0);
    chk("pend_new_addr", bus.instr_address_out, 32'h200);
    tick();
    chk("pend_pc", pc_out, 32'h200);
    chk("pend_pc_valid", valid_out, 1);

    // access fault at 0x40, then trap resumes at 0x80
    branch_mispredicted_in = 1'b1;
    branch_pc_in = 32'h40;
    tick();
    branch_mispredicted_in = 1'b0;
    tick();
    chk("fault_valid", valid_out, 1);
    chk("fault_exc", exception_out, 1);
    chk("fault_cause", exception_cause_out, 1);
    chk("fault_pred", branch_predicted_taken_out, 0);
    chk("fault_pc", pc_out, 32'h40);
    chk("fault_read", bus.instr_read_out, 0);
    tick();
    chk("halt_read", bus.instr_read_out, 0);
    chk("halt_valid", valid_out, 0);
    trap_in = 1'b1;
    trap_pc_in = 32'h80;
    tick();
    trap_in = 1'b0;
    chk("trap_read", bus.instr_read_out, 1);
    chk("trap_addr", bus.instr_address_out, 32'h80);
    tick();
    chk("trap_pc", pc_out, 32'h80);
    chk("trap_exc", exception_out, 0);

    // misaligned trap target
    trap_in = 1'b1;
    trap_pc_in = 32'h82;
    tick();
    trap_in = 1'b0;
    chk("mis_valid", valid_out, 1);
    chk("mis_exc", exception_out, 1);
    chk("mis_cause", exception_cause_out, 0);
    chk("mis_instr", instr_out, 0);
    chk("mis_pc", pc_out, 32'h82);
    chk("mis_read", bus.instr_read_out, 0);
    tick();
    chk("mis_halt_read", bus.instr_read_out, 0);

    // trap and mispredict together: trap wins
    trap_in = 1'b1;
    trap_pc_in = 32'h300;
    branch_mispredicted_in = 1'b1;
    branch_pc_in = 32'h400;
    tick();
    trap_in = 1'b0;
    branch_mispredicted_in = 1'b0;
    chk("both_addr", bus.instr_address_out, 32'h300);
    tick();
    chk("both_pc", pc_out, 32'h300);

    // flush squashes but PC advances
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("flush_valid", valid_out, 0);
    chk("flush_addr", bus.instr_address_out, 32'h308);

    // reset mid-transaction
    mem_en = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst2_read", bus.instr_read_out, 0);
    chk("rst2_addr", bus.instr_address_out, 32'h0);
    chk("rst2_valid", valid_out, 0);
    reset = 1'b0;
    mem_en = 1'b1;
    tick();
    chk("rst2_req", bus.instr_read_out, 1);
    tick();
    chk("rst2_pc", pc_out, 32'h0);
    chk("rst2_pvalid", valid_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
